// File: rtl/ringbuffer_sequencer_if.sv
// Bundle of the command-pop, master-core and response-push signals seen by the sequencer.
// master modport is the sequencer side; slave is the ringbuffer/master-core side.
interface ringbuffer_sequencer_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 64
);
  logic                buffer_empty;
  logic                cmd_pop_req;
  logic                cmd_pop_ack;
  logic                cmd_pop_struct_op;
  logic [ADDR_W-1:0]   cmd_pop_struct_address;
  logic [DATA_W-1:0]   cmd_pop_struct_wdata;
  logic [DATA_W/8-1:0] cmd_pop_struct_wstrb;

  logic                mst_start;
  logic                mst_op;
  logic [ADDR_W-1:0]   mst_addr;
  logic [DATA_W-1:0]   mst_wdata;
  logic [DATA_W/8-1:0] mst_wstrb;
  logic                mst_done;
  logic [DATA_W-1:0]   mst_rdata;
  logic [1:0]          mst_status;
  logic                mst_abort;

  logic                resp_push_req;
  logic                resp_push_ack;
  logic                resp_push_struct_op;
  logic [ADDR_W-1:0]   resp_push_struct_address;
  logic [DATA_W-1:0]   resp_push_struct_rdata;
  logic [1:0]          resp_push_struct_status;

  modport master (
    input  buffer_empty, cmd_pop_ack, cmd_pop_struct_op, cmd_pop_struct_address,
           cmd_pop_struct_wdata, cmd_pop_struct_wstrb, mst_done, mst_rdata, mst_status,
           resp_push_ack,
    output cmd_pop_req, mst_start, mst_op, mst_addr, mst_wdata, mst_wstrb, mst_abort,
           resp_push_req, resp_push_struct_op, resp_push_struct_address,
           resp_push_struct_rdata, resp_push_struct_status
  );

  modport slave (
    output buffer_empty, cmd_pop_ack, cmd_pop_struct_op, cmd_pop_struct_address,
           cmd_pop_struct_wdata, cmd_pop_struct_wstrb, mst_done, mst_rdata, mst_status,
           resp_push_ack,
    input  cmd_pop_req, mst_start, mst_op, mst_addr, mst_wdata, mst_wstrb, mst_abort,
           resp_push_req, resp_push_struct_op, resp_push_struct_address,
           resp_push_struct_rdata, resp_push_struct_status
  );
endinterface

// File: rtl/ringbuffer_sequencer.sv
// Drains the command ring one command at a time through the master core into the response ring.
// Optional master-done timeout with abort is enabled by defining SEQ_TIMEOUT_EN.
module ringbuffer_sequencer #(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = 64,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   seq_en,
  ringbuffer_sequencer_if.master bus,
  output logic                   busy,
  output logic [15:0]            cmd_count
);

  typedef enum logic [2:0] {StIdle, StPop, StIssue, StWait, StPush, StRelease} state_e;

  state_e state_q, state_d;

  logic                pop_req_q, pop_req_d;
  logic                start_q, start_d;
  logic                push_req_q, push_req_d;
  logic                busy_q, busy_d;
  logic                abort_q, abort_d;
  logic [15:0]         count_q;
  logic                mst_op_q;
  logic [ADDR_W-1:0]   mst_addr_q;
  logic [DATA_W-1:0]   mst_wdata_q;
  logic [DATA_W/8-1:0] mst_wstrb_q;
  logic                resp_op_q;
  logic [ADDR_W-1:0]   resp_addr_q;
  logic [DATA_W-1:0]   resp_rdata_q;
  logic [1:0]          resp_status_q;
  logic                expired;

`ifdef SEQ_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CntW-1:0] tmo_cnt_q;

  // Expiry is the TIMEOUT_CYCLES-th WAIT cycle; the abort flop fires the cycle after.
  assign expired = (state_q == StWait) && (tmo_cnt_q == CntW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset || state_q != StWait) begin
      tmo_cnt_q <= '0;
    end else begin
      tmo_cnt_q <= tmo_cnt_q + CntW'(1);
    end
  end
`else
  assign expired = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (seq_en && !bus.buffer_empty) state_d = StPop;
      StPop:     if (bus.cmd_pop_ack) state_d = StIssue;
      StIssue:   state_d = StWait;
      StWait:    if (bus.mst_done || expired) state_d = StPush;
      StPush:    if (bus.resp_push_ack) state_d = StRelease;
      StRelease: if (!bus.cmd_pop_ack && !bus.resp_push_ack) state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  // Outputs are decoded from the next state so that every output leaves a flop.
  always_comb begin
    pop_req_d  = (state_d == StPop);
    start_d    = (state_d == StIssue);
    push_req_d = (state_d == StPush);
    busy_d     = (state_d != StIdle);
    abort_d    = expired && !bus.mst_done;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pop_req_q     <= 1'b0;
      start_q       <= 1'b0;
      push_req_q    <= 1'b0;
      busy_q        <= 1'b0;
      abort_q       <= 1'b0;
      count_q       <= '0;
      mst_op_q      <= 1'b0;
      mst_addr_q    <= '0;
      mst_wdata_q   <= '0;
      mst_wstrb_q   <= '0;
      resp_op_q     <= 1'b0;
      resp_addr_q   <= '0;
      resp_rdata_q  <= '0;
      resp_status_q <= '0;
    end else begin
      pop_req_q  <= pop_req_d;
      start_q    <= start_d;
      push_req_q <= push_req_d;
      busy_q     <= busy_d;
      abort_q    <= abort_d;
      if (state_q == StPop && bus.cmd_pop_ack) begin
        mst_op_q    <= bus.cmd_pop_struct_op;
        mst_addr_q  <= bus.cmd_pop_struct_address;
        mst_wdata_q <= bus.cmd_pop_struct_wdata;
        mst_wstrb_q <= bus.cmd_pop_struct_wstrb;
      end
      if (state_q == StWait && (bus.mst_done || expired)) begin
        resp_op_q   <= mst_op_q;
        resp_addr_q <= mst_addr_q;
        if (bus.mst_done) begin
          resp_rdata_q  <= mst_op_q ? '0 : bus.mst_rdata;
          resp_status_q <= bus.mst_status;
        end else begin
          resp_rdata_q  <= '0;
          resp_status_q <= 2'b11;
        end
      end
      if (state_q == StPush && bus.resp_push_ack) begin
        count_q <= count_q + 16'd1;
      end
    end
  end

  assign bus.cmd_pop_req              = pop_req_q;
  assign bus.mst_start                = start_q;
  assign bus.mst_op                   = mst_op_q;
  assign bus.mst_addr                 = mst_addr_q;
  assign bus.mst_wdata                = mst_wdata_q;
  assign bus.mst_wstrb                = mst_wstrb_q;
  assign bus.mst_abort                = abort_q;
  assign bus.resp_push_req            = push_req_q;
  assign bus.resp_push_struct_op      = resp_op_q;
  assign bus.resp_push_struct_address = resp_addr_q;
  assign bus.resp_push_struct_rdata   = resp_rdata_q;
  assign bus.resp_push_struct_status  = resp_status_q;
  assign busy                         = busy_q;
  assign cmd_count                    = count_q;

endmodule

// File: tb/tb_ringbuffer_sequencer.sv
// Directed self-checking bench for ringbuffer_sequencer; plays ringbuffer and master core.
// Timeout steps run only when SEQ_TIMEOUT_EN is defined (TIMEOUT_CYCLES = 8).
module tb_ringbuffer_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        seq_en;
  logic        busy;
  logic [15:0] cmd_count;

  int n_cmp = 0;
  int n_err = 0;
  int exp_count = 0;

  ringbuffer_sequencer_if #(.ADDR_W(32), .DATA_W(64)) bus ();

  ringbuffer_sequencer #(
    .ADDR_W(32),
    .DATA_W(64),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk),
    .reset(reset),
    .seq_en(seq_en),
    .bus(bus),
    .busy(busy),
    .cmd_count(cmd_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Returns the number of cycles cmd_pop_req was low before rising.
  task automatic wait_pop(input string tag, output int low);
    low = 0;
    while (!bus.cmd_pop_req && low < 40) begin
      tick();
      low++;
    end
    chk({tag, " pop_req"}, 64'(bus.cmd_pop_req), 64'd1);
  endtask

  task automatic serve(input string tag, input logic op, input logic [31:0] addr,
                       input logic [63:0] wd, input logic [7:0] ws, input logic [63:0] rd,
                       input logic [1:0] st, input int hold, input logic last,
                       input logic drop_en, output int low);
    bus.cmd_pop_struct_op      = op;
    bus.cmd_pop_struct_address = addr;
    bus.cmd_pop_struct_wdata   = wd;
    bus.cmd_pop_struct_wstrb   = ws;
    wait_pop(tag, low);
    bus.cmd_pop_ack = 1'b1;
    if (last) bus.buffer_empty = 1'b1;
    tick();
    chk({tag, " start"}, 64'(bus.mst_start), 64'd1);
    chk({tag, " pop_req fall"}, 64'(bus.cmd_pop_req), 64'd0);
    chk({tag, " mst_op"}, 64'(bus.mst_op), 64'(op));
    chk({tag, " mst_addr"}, 64'(bus.mst_addr), 64'(addr));
    chk({tag, " mst_wdata"}, bus.mst_wdata, wd);
    chk({tag, " mst_wstrb"}, 64'(bus.mst_wstrb), 64'(ws));
    if (drop_en) seq_en = 1'b0;
    repeat (hold) tick();
    bus.cmd_pop_ack = 1'b0;
    tick();
    chk({tag, " start one-shot"}, 64'(bus.mst_start), 64'd0);
    bus.mst_done   = 1'b1;
    bus.mst_rdata  = rd;
    bus.mst_status = st;
    tick();
    bus.mst_done   = 1'b0;
    bus.mst_rdata  = '0;
    bus.mst_status = '0;
    chk({tag, " push_req"}, 64'(bus.resp_push_req), 64'd1);
    chk({tag, " resp op"}, 64'(bus.resp_push_struct_op), 64'(op));
    chk({tag, " resp addr"}, 64'(bus.resp_push_struct_address), 64'(addr));
    chk({tag, " resp rdata"}, bus.resp_push_struct_rdata, op ? 64'd0 : rd);
    chk({tag, " resp status"}, 64'(bus.resp_push_struct_status), 64'(st));
    bus.resp_push_ack = 1'b1;
    tick();
    exp_count++;
    chk({tag, " push_req fall"}, 64'(bus.resp_push_req), 64'd0);
    chk({tag, " cmd_count"}, 64'(cmd_count), 64'(exp_count));
    bus.resp_push_ack = 1'b0;
  endtask

  initial begin
    int low;
    int hits;
    reset = 1'b1;
    seq_en = 1'b0;
    bus.buffer_empty = 1'b1;
    bus.cmd_pop_ack = 1'b0;
    bus.cmd_pop_struct_op = 1'b0;
    bus.cmd_pop_struct_address = '0;
    bus.cmd_pop_struct_wdata = '0;
    bus.cmd_pop_struct_wstrb = '0;
    bus.mst_done = 1'b0;
    bus.mst_rdata = '0;
    bus.mst_status = '0;
    bus.resp_push_ack = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
    tick();

    chk("reset busy", 64'(busy), 64'd0);
    chk("reset pop_req", 64'(bus.cmd_pop_req), 64'd0);
    chk("reset push_req", 64'(bus.resp_push_req), 64'd0);
    chk("reset start", 64'(bus.mst_start), 64'd0);
    chk("reset abort", 64'(bus.mst_abort), 64'd0);
    chk("reset cmd_count", 64'(cmd_count), 64'd0);
    chk("reset mst_addr", 64'(bus.mst_addr), 64'd0);

    // Single read: pop_req rises the cycle after the IDLE condition.
    seq_en = 1'b1;
    bus.buffer_empty = 1'b0;
    serve("read", 1'b0, 32'h1000, 64'd0, 8'h00, 64'hDEAD_BEEF_CAFE_F00D, 2'b00, 0, 1'b1,
          1'b0, low);
    chk("read pop latency", 64'(low), 64'd1);
    bus.resp_push_ack = 1'b1;
    tick();
    chk("release holds on ack", 64'(busy), 64'd1);
    bus.resp_push_ack = 1'b0;
    tick();
    chk("idle after release", 64'(busy), 64'd0);

    // Write: rdata forced to 0 regardless of what the master returns.
    bus.buffer_empty = 1'b0;
    serve("write", 1'b1, 32'h20, 64'h55, 8'h0F, 64'h1234_5678_9ABC_DEF0, 2'b10, 0, 1'b1,
          1'b0, low);

    // Back-to-back with long pop acks.
    bus.buffer_empty = 1'b0;
    serve("b2b0", 1'b0, 32'h100, 64'd0, 8'h00, 64'h1111, 2'b00, 3, 1'b0, 1'b0, low);
    serve("b2b1", 1'b1, 32'h104, 64'hAA, 8'hFF, 64'h2222, 2'b01, 3, 1'b0, 1'b0, low);
    chk("b2b1 gap", 64'(low >= 1), 64'd1);
    serve("b2b2", 1'b0, 32'h108, 64'd0, 8'h00, 64'h3333, 2'b11, 3, 1'b1, 1'b0, low);
    chk("b2b2 gap", 64'(low >= 1), 64'd1);

    // Gating: disabled sequencer never leaves IDLE.
    repeat (3) tick();
    seq_en = 1'b0;
    bus.buffer_empty = 1'b0;
    hits = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (busy) hits++;
    end
    chk("gated busy cycles", 64'(hits), 64'd0);

    // seq_en dropped mid-command: command completes, no further pop.
    seq_en = 1'b1;
    serve("drop", 1'b0, 32'h40, 64'd0, 8'h00, 64'hBEEF, 2'b00, 0, 1'b0, 1'b1, low);
    hits = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.cmd_pop_req) hits++;
    end
    chk("no pop after drop", 64'(hits), 64'd0);
    chk("idle after drop", 64'(busy), 64'd0);

    // Reset during WAIT.
    seq_en = 1'b1;
    bus.cmd_pop_struct_op = 1'b1;
    bus.cmd_pop_struct_address = 32'h88;
    bus.cmd_pop_struct_wdata = 64'h99;
    wait_pop("rst", low);
    bus.cmd_pop_ack = 1'b1;
    tick();
    bus.cmd_pop_ack = 1'b0;
    tick();
    chk("rst busy before", 64'(busy), 64'd1);
    reset = 1'b1;
    seq_en = 1'b0;
    tick();
    reset = 1'b0;
    exp_count = 0;
    chk("rst busy", 64'(busy), 64'd0);
    chk("rst cmd_count", 64'(cmd_count), 64'd0);
    chk("rst mst_addr", 64'(bus.mst_addr), 64'd0);
    chk("rst mst_wdata", bus.mst_wdata, 64'd0);
    chk("rst resp addr", 64'(bus.resp_push_struct_address), 64'd0);
    bus.mst_done = 1'b1;
    bus.mst_status = 2'b01;
    tick();
    bus.mst_done = 1'b0;
    tick();
    chk("late done push_req", 64'(bus.resp_push_req), 64'd0);
    chk("late done busy", 64'(busy), 64'd0);
    chk("late done status", 64'(bus.resp_push_struct_status), 64'd0);

`ifdef SEQ_TIMEOUT_EN
    // Timeout: no done for 8 WAIT cycles -> abort on the 9th cycle after entry edge.
    seq_en = 1'b1;
    bus.buffer_empty = 1'b0;
    bus.cmd_pop_struct_op = 1'b0;
    bus.cmd_pop_struct_address = 32'h300;
    wait_pop("tmo", low);
    bus.cmd_pop_ack = 1'b1;
    bus.buffer_empty = 1'b1;
    tick();
    bus.cmd_pop_ack = 1'b0;
    tick();
    hits = 0;
    for (int i = 0; i < 7; i++) begin
      if (bus.mst_abort) hits++;
      tick();
    end
    if (bus.mst_abort) hits++;
    chk("tmo early abort", 64'(hits), 64'd0);
    tick();
    chk("tmo abort", 64'(bus.mst_abort), 64'd1);
    chk("tmo push_req", 64'(bus.resp_push_req), 64'd1);
    chk("tmo status", 64'(bus.resp_push_struct_status), 64'd3);
    chk("tmo rdata", bus.resp_push_struct_rdata, 64'd0);
    bus.mst_done = 1'b1;
    bus.mst_rdata = 64'hABCD;
    bus.mst_status = 2'b00;
    tick();
    bus.mst_done = 1'b0;
    chk("tmo abort one-shot", 64'(bus.mst_abort), 64'd0);
    chk("tmo late done ignored", 64'(bus.resp_push_struct_status), 64'd3);
    bus.resp_push_ack = 1'b1;
    tick();
    bus.resp_push_ack = 1'b0;
    exp_count++;
    chk("tmo cmd_count", 64'(cmd_count), 64'(exp_count));

    // Done in the expiry cycle wins.
    bus.buffer_empty = 1'b0;
    bus.cmd_pop_struct_address = 32'h304;
    wait_pop("edge", low);
    bus.cmd_pop_ack = 1'b1;
    bus.buffer_empty = 1'b1;
    tick();
    bus.cmd_pop_ack = 1'b0;
    tick();
    repeat (7) tick();
    bus.mst_done = 1'b1;
    bus.mst_rdata = 64'h77;
    bus.mst_status = 2'b01;
    tick();
    bus.mst_done = 1'b0;
    chk("edge abort", 64'(bus.mst_abort), 64'd0);
    chk("edge push_req", 64'(bus.resp_push_req), 64'd1);
    chk("edge status", 64'(bus.resp_push_struct_status), 64'd1);
    chk("edge rdata", bus.resp_push_struct_rdata, 64'h77);
    tick();
    chk("edge abort later", 64'(bus.mst_abort), 64'd0);
    bus.resp_push_ack = 1'b1;
    tick();
    bus.resp_push_ack = 1'b0;
`else
    chk("abort tied low", 64'(bus.mst_abort), 64'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
